// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave bit engine: synchronises cs/sclk/mosi, deserialises mosi into
// DATA_WIDTH-bit words and serialises host words onto miso, MSB first.
module spi_slave_driver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  load,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  abort,
    output logic                  busy
);
    localparam int                CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_CS_HIGH,
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state;
    logic [1:0]              cs_sync, sclk_sync, mosi_sync;
    logic                    cs_d, sclk_d;
    logic                    cs_s, sclk_s, mosi_s;
    logic                    cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [1:0]              sync_warm;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_tx, shift_rx, rx_next;
    logic                    rx_done;

    assign cs_s      = cs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign rx_next   = {shift_rx[DATA_WIDTH-2:0], mosi_s};
    assign miso      = busy & shift_tx[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_CS_HIGH;
            sync_warm <= 2'd0;
            bit_cnt   <= '0;
            shift_tx  <= '0;
            shift_rx  <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            load      <= 1'b0;
            ready     <= 1'b0;
            abort     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            load    <= 1'b0;
            abort   <= 1'b0;
            rx_done <= 1'b0;
            ready   <= rx_done;
            if (sync_warm != 2'd3)
                sync_warm <= sync_warm + 2'd1;

            case (state)
                // The cs synchroniser comes out of reset reading "high"; wait until
                // the real pin level has flushed through before trusting cs_s.
                WAIT_CS_HIGH: begin
                    if (sync_warm == 2'd3 && cs_s)
                        state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        shift_tx <= data_in;
                        load     <= 1'b1;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        abort   <= (bit_cnt != '0);
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        shift_rx <= rx_next;
                        if (bit_cnt == LAST) begin
                            data_out <= rx_next;
                            rx_done  <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt  <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        // bit_cnt==0 on a falling edge means a word just completed.
                        if (bit_cnt != '0) begin
                            shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            shift_tx <= data_in;
                            load     <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_CS_HIGH;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_driver.sv
// Scoreboard bench for spi_slave_driver: a bit-banged SPI master and a host model
// feed expected words into queues; a monitor checks every ready/load/abort.
module tb_spi_slave_driver;
    localparam int W    = 8;
    localparam int HALF = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cs = 1'b0, sclk = 1'b0, mosi = 1'b0;
    logic         miso, load, ready, abort, busy;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;

    int checks = 0, errors = 0;
    int n_load = 0, n_ready = 0, n_abort = 0, n_busy = 0;
    logic [W-1:0] exp_rx[$], exp_tx[$], host_next[$], prime_q[$];

    spi_slave_driver #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .data_in(data_in), .load(load), .data_out(data_out), .ready(ready),
        .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Host: every load consumes the presented word; next word is scripted or random.
    initial forever begin
        @(negedge clk);
        if (load === 1'b1) begin
            exp_tx.push_back(data_in);
            data_in = (host_next.size() > 0) ? host_next.pop_front() : W'($urandom);
        end else if (busy !== 1'b1 && prime_q.size() > 0) begin
            data_in = prime_q.pop_front();
        end
    end

    // Monitor: pops the expected received word on every ready pulse.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1)  n_busy++;
            if (load === 1'b1)  n_load++;
            if (abort === 1'b1) n_abort++;
            if (ready === 1'b1) begin
                n_ready++;
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: data_out 0x%0h with nothing pending", data_out);
                end else begin
                    e = exp_rx.pop_front();
                    chk("rx_word", int'(data_out), int'(e));
                end
            end
            if (busy !== 1'b1) begin
                checks++;
                if (miso !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_miso: got %b, expected 0", miso);
                end
            end
        end
    end

    // One mode-0 bit: data set, master samples miso and raises sclk; caller lowers sclk.
    task automatic bit_xfer(input logic b, output logic s);
        mosi = b;
        wclk(HALF);
        s = miso;
        sclk = 1'b1;
        wclk(HALF);
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            wclk(HALF);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"},  int'(miso), 0);
        chk({tag, "_load"},  int'(load), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_abort"}, int'(abort), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_data_out"}, int'(data_out), 0);
    endtask

    // n full words, then optionally cut_bits of one more word ended by
    // cs rising (cut_mode 1) or by an rst pulse (cut_mode 2). A normal frame
    // ends with cs rising together with the last sclk fall.
    task automatic frame(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [W-1:0] w2, input int cut_bits, input int cut_mode);
        logic [W-1:0] wds [3];
        logic [W-1:0] got, e;
        logic s;
        wds[0] = w0; wds[1] = w1; wds[2] = w2;
        got = '0;
        cs = 1'b0;
        wclk(HALF);
        for (int i = 0; i < n; i++) begin
            exp_rx.push_back(wds[i]);
            for (int b = W - 1; b >= 0; b--) begin
                bit_xfer(wds[i][b], s);
                got[b] = s;
                if (cut_mode == 0 && i == n - 1 && b == 0) cs = 1'b1;
                sclk = 1'b0;
            end
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso_word: got 0x%0h, expected a loaded word, none loaded", got);
            end else begin
                e = exp_tx.pop_front();
                chk("miso_word", int'(got), int'(e));
            end
        end
        if (cut_mode != 0) begin
            for (int b = 0; b < cut_bits; b++) begin
                bit_xfer(wds[n][W-1-b], s);
                sclk = 1'b0;
            end
            wclk(HALF);
            if (cut_mode == 1) begin
                cs = 1'b1;
            end else begin
                rst = 1'b1;
                wclk(1);
                check_reset_outputs("rst_mid");
                rst = 1'b0;
                cs = 1'b1;
            end
            if (exp_tx.size() > 0) void'(exp_tx.pop_front());
        end
        wclk(3 * HALF);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, r0, a0, nw, cm, cb;
        logic [W-1:0] a, b, c;

        // Reset held with cs low and sclk toggling afterwards: nothing may start.
        wclk(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        toggles(8);
        wclk(4);
        chk("t1_busy", n_busy, 0);
        chk("t1_load", n_load, 0);
        chk("t1_ready", n_ready, 0);
        cs = 1'b1;
        wclk(8);
        a = W'($urandom);
        frame(1, a, '0, '0, 0, 0);
        chk("t1_data_out", int'(data_out), int'(a));

        prime_q.push_back(8'h3C);
        wclk(2);
        l0 = n_load; r0 = n_ready;
        frame(1, 8'hA5, '0, '0, 0, 0);
        chk("t2_data_out", int'(data_out), 'hA5);
        chk("t2_ready_cnt", n_ready - r0, 1);
        chk("t2_load_cnt", n_load - l0, 1);

        host_next.push_back(8'hF0);
        l0 = n_load; r0 = n_ready;
        frame(2, 8'h01, 8'h80, '0, 0, 0);
        chk("t3_data_out", int'(data_out), 'h80);
        chk("t3_ready_cnt", n_ready - r0, 2);
        chk("t3_load_cnt", n_load - l0, 2);

        frame(1, 8'h5A, '0, '0, 0, 0);
        l0 = n_load; r0 = n_ready; a0 = n_abort;
        frame(0, W'($urandom), '0, '0, 5, 1);
        chk("t4_abort_cnt", n_abort - a0, 1);
        chk("t4_ready_cnt", n_ready - r0, 0);
        chk("t4_data_out", int'(data_out), 'h5A);
        chk("t4_busy", int'(busy), 0);
        chk("t4_miso", int'(miso), 0);

        l0 = n_load; r0 = n_ready; a0 = n_abort;
        toggles(16);
        wclk(4);
        chk("t5_load_cnt", n_load - l0, 0);
        chk("t5_ready_cnt", n_ready - r0, 0);
        chk("t5_abort_cnt", n_abort - a0, 0);
        chk("t5_miso", int'(miso), 0);
        a = W'($urandom);
        frame(1, a, '0, '0, 0, 0);
        chk("t5_data_out", int'(data_out), int'(a));

        frame(0, W'($urandom), '0, '0, 4, 2);
        wclk(8);
        frame(1, 8'hC3, '0, '0, 0, 0);
        chk("t6_data_out", int'(data_out), 'hC3);

        for (int f = 0; f < 20; f++) begin
            cm = ($urandom_range(0, 3) == 0) ? 1 : 0;
            nw = (cm == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
            cb = int'($urandom_range(1, W - 1));
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            l0 = n_load; r0 = n_ready; a0 = n_abort;
            frame(nw, a, b, c, cb, cm);
            chk("rnd_ready_cnt", n_ready - r0, nw);
            chk("rnd_load_cnt", n_load - l0, nw + cm);
            chk("rnd_abort_cnt", n_abort - a0, cm);
        end

        wclk(10);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
